// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS core front end.
//   OPCODE_*      : opcode field position/width and the J-type opcode
//   JUMP_INDEX_W  : width of the J-type instruction index field
//   INSTR_NOP     : all-zero NOP encoding presented when no instruction is valid
//   PC_STEP       : sequential PC increment in bytes
//   fetch_state_t : fetch response state (empty after reset, streaming after)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int JUMP_INDEX_W = 26;

    localparam logic [OPCODE_W-1:0] OPCODE_J  = 6'b000010;
    localparam logic [31:0]         INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0]         PC_STEP   = 32'd4;

    typedef enum logic {
        ST_EMPTY     = 1'b0,
        ST_STREAMING = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, drives the synchronous instruction memory address
// and pairs each returned instruction with its PC for decode.
//
// Optional feature macro: FETCH_JUMP_PREDECODE_EN
//   defined   : J-type instructions accepted by decode steer the next fetch
//               to the jump target with zero bubble.
//   undefined : jumps resolve only through redirect_valid.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr         : address to instruction memory (combinational)
//   imem_instruction  : memory read data for the address issued last edge
//   redirect_valid    : later stage redirects fetch this cycle
//   redirect_target   : redirect address (bits [1:0] forced to 0)
//   if_valid/if_ready : handshake to decode
//   if_instruction    : fetched instruction, NOP when if_valid=0
//   if_pc, if_pc_plus4: address of if_instruction and that address + 4
//
// state        | meaning
// ST_EMPTY     | after reset, no read in flight
// ST_STREAMING | a read was issued on the last edge; response is at the memory
// -----------------------------------------------------------------------------
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                  WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_instruction,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_target,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [WORD_SIZE-1:0] if_instruction,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_pc_plus4
);

    localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(PC_STEP);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

    fetch_state_t         state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] rsp_pc;
    logic                 stall;
    logic                 jump_take;
    logic [WORD_SIZE-1:0] jump_target;
    logic [WORD_SIZE-1:0] redirect_aligned;

    assign redirect_aligned = redirect_target & ALIGN_MASK;

    // The wrong-path response is killed in the redirect cycle.
    assign if_valid       = (state == ST_STREAMING) & ~redirect_valid;
    assign stall          = if_valid & ~if_ready;
    assign if_pc          = rsp_pc;
    assign if_pc_plus4    = rsp_pc + STEP;
    assign if_instruction = if_valid ? imem_instruction : WORD_SIZE'(INSTR_NOP);

`ifdef FETCH_JUMP_PREDECODE_EN
    // Only predecode an instruction decode actually takes this cycle.
    assign jump_take   = if_valid & if_ready & ~redirect_valid &
                         (imem_instruction[OPCODE_MSB:OPCODE_LSB] == OPCODE_J);
    assign jump_target = {if_pc_plus4[WORD_SIZE-1:28],
                          imem_instruction[JUMP_INDEX_W-1:0], 2'b00};
`else
    assign jump_take   = 1'b0;
    assign jump_target = '0;
`endif

    // Under stall the held response address is re-read so the memory output
    // (and therefore if_instruction) stays bit-stable.
    always_comb begin
        imem_addr = pc;
        if (redirect_valid) begin
            imem_addr = redirect_aligned;
        end else if (jump_take) begin
            imem_addr = jump_target;
        end else if (stall) begin
            imem_addr = rsp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            pc     <= RESET_ADDR;
            rsp_pc <= '0;
        end else begin
            state  <= ST_STREAMING;
            rsp_pc <= imem_addr;
            pc     <= imem_addr + STEP;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];

    instruction_fetch #(
        .WORD_SIZE  (32),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle registered read, 64 words aliased.
    always @(posedge clk) imem_instruction <= mem[imem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        #1;
        check({tag, " valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, " pc"}, if_pc, pc);
        check({tag, " instr"}, if_instruction, instr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h2001_0004;
        mem[1]  = 32'h2002_0006;
        mem[2]  = 32'h0022_1820;
        mem[3]  = 32'h0800_0000;
        mem[4]  = 32'h3c0b_1234;
        mem[63] = 32'h1111_1111;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        if_ready = 1'b1;
        imem_instruction = 32'h0;

        #12;
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst valid", {31'd0, if_valid}, 32'd0);
        check("rst instr", if_instruction, 32'h0);
        check("rst pc", if_pc, 32'h0);
        check("rst pc_plus4", if_pc_plus4, 32'h4);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("empty valid", {31'd0, if_valid}, 32'd0);

        // Streaming
        tick(); expect_slot("s0", 32'h0, 32'h2001_0004);
        check("s0 addr", imem_addr, 32'h4);
        tick(); expect_slot("s1", 32'h4, 32'h2002_0006);

        // Stall 3 cycles at pc=4
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            expect_slot("stall", 32'h4, 32'h2002_0006);
            check("stall addr", imem_addr, 32'h4);
        end
        tick();
        if_ready = 1'b1;
        expect_slot("release", 32'h4, 32'h2002_0006);
        check("release addr", imem_addr, 32'h8);
        tick(); expect_slot("after stall", 32'h8, 32'h0022_1820);

        // Redirect to misaligned 6 while if_pc=8
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0006;
        #1;
        check("redir kill", {31'd0, if_valid}, 32'd0);
        check("redir kill instr", if_instruction, 32'h0);
        check("redir addr", imem_addr, 32'h4);
        tick();
        redirect_valid = 1'b0;
        expect_slot("redir tgt", 32'h4, 32'h2002_0006);

        // Redirect together with stall
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        #1;
        check("redir+stall kill", {31'd0, if_valid}, 32'd0);
        check("redir+stall addr", imem_addr, 32'h0);
        tick();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        expect_slot("redir+stall tgt", 32'h0, 32'h2001_0004);

        tick(); expect_slot("j s1", 32'h4, 32'h2002_0006);
        tick(); expect_slot("j s2", 32'h8, 32'h0022_1820);
        tick(); expect_slot("j slot", 32'hC, 32'h0800_0000);
`ifdef FETCH_JUMP_PREDECODE_EN
        check("j addr", imem_addr, 32'h0);
        tick(); expect_slot("j target", 32'h0, 32'h2001_0004);
`else
        check("j addr", imem_addr, 32'h10);
        tick(); expect_slot("j seq", 32'h10, 32'h3c0b_1234);
        redirect_valid = 1'b1;
        redirect_target = 32'h0;
        #1;
        check("j redir kill", {31'd0, if_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        expect_slot("j redir tgt", 32'h0, 32'h2001_0004);
`endif

        // PC wrap
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        #1;
        check("wrap redir addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        expect_slot("wrap top", 32'hFFFF_FFFC, 32'h1111_1111);
        check("wrap plus4", if_pc_plus4, 32'h0);
        check("wrap addr", imem_addr, 32'h0);
        tick(); expect_slot("wrap zero", 32'h0, 32'h2001_0004);
        tick(); expect_slot("pre rst 4", 32'h4, 32'h2002_0006);
        tick(); expect_slot("pre rst 8", 32'h8, 32'h0022_1820);

        // Async reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", {31'd0, if_valid}, 32'd0);
        check("mid rst instr", if_instruction, 32'h0);
        check("mid rst pc", if_pc, 32'h0);
        check("mid rst addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart empty", {31'd0, if_valid}, 32'd0);
        tick(); expect_slot("restart 0", 32'h0, 32'h2001_0004);
        tick(); expect_slot("restart 4", 32'h4, 32'h2002_0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
